// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader_pkg : loader state type and NOP encoding          rev 1.0    |
// +--------------------------------------------------------------------------+
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } loader_state_t;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader_if : byte-stream valid/ready boot-loader port     rev 1.0    |
// +--------------------------------------------------------------------------+
interface imem_loader_if;

  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface
`default_nettype wire

// File: rtl/imem_loader_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_array : instruction storage with per-word valid bits     rev 1.0    |
// +--------------------------------------------------------------------------+
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [31:0]       wdata,
  input  wire logic              clr_valid,
  input  wire logic              rd_en,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic [31:0]            rdata
);

  logic [31:0]            mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] valid;

  // Contents are deliberately not reset; the valid bits alone decide visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_valid
      logic valid_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_bit <= 1'b0;
        end else if (clr_valid) begin
          valid_bit <= 1'b0;
        end else if (we && (waddr == ADDR_W'(i))) begin
          valid_bit <= 1'b1;
        end
      end

      assign valid[i] = valid_bit;
    end
  endgenerate

  assign rdata = (rd_en && valid[raddr]) ? mem[raddr] : NOP_INSTR;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader : instruction memory with byte-stream boot loader rev 1.0    |
// +--------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  imem_loader_if.slave     ld,
  input  wire logic        reload,
  input  wire logic [31:0] PC,
  output logic [31:0]      Instr,
  output logic             core_reset,
  output logic             load_done,
  output logic             load_err,
  output logic [ADDR_W:0]  word_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH_WORDS);

  loader_state_t   state;
  loader_state_t   state_next;
  logic [ADDR_W:0] wr_ptr;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_word;
  logic            accept;
  logic            full;
  logic            restart;
  logic            word_we;
  logic            pc_in_range;
  logic            unused_pc_bits;

  assign accept  = ld.ld_valid && (state == LOAD);
  assign full    = (wr_ptr == FULL_COUNT);
  assign restart = reload && (state != LOAD);
  assign word_we = accept && !full && (byte_idx == 2'd3);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (accept) begin
          if (full) begin
            state_next = ERR;
          end else if (ld.ld_last) begin
            state_next = (byte_idx == 2'd3) ? DONE : ERR;
          end
        end
      end
      DONE, ERR: begin
        if (reload) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    ld.ld_ready = 1'b0;
    core_reset  = 1'b1;
    load_done   = 1'b0;
    load_err    = 1'b0;
    case (state)
      LOAD: ld.ld_ready = 1'b1;
      DONE: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      ERR:     load_err = 1'b1;
      default: ;
    endcase
  end

  // Byte assembler: lanes 0..2 are staged, lane 3 goes straight into the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      byte_idx <= '0;
      asm_word <= '0;
    end else if (restart) begin
      wr_ptr   <= '0;
      byte_idx <= '0;
    end else if (accept && !full) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    asm_word[7:0]   <= ld.ld_data;
        2'd1:    asm_word[15:8]  <= ld.ld_data;
        2'd2:    asm_word[23:16] <= ld.ld_data;
        default: wr_ptr          <= wr_ptr + 1'b1;
      endcase
    end
  end

  assign word_count = wr_ptr;

  // Any address beyond the array, including aliases, fetches a NOP.
  assign pc_in_range    = (PC[31:ADDR_W+2] == '0);
  assign unused_pc_bits = ^PC[1:0];

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .we        (word_we),
    .waddr     (wr_ptr[ADDR_W-1:0]),
    .wdata     ({ld.ld_data, asm_word}),
    .clr_valid (restart),
    .rd_en     (pc_in_range),
    .raddr     (PC[ADDR_W+1:2]),
    .rdata     (Instr)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: directed + randomized bench for two imem_loader instances (64 and 4 words)
// checked every cycle against a byte-list reference model.
module tb_imem_loader;

  localparam int          DA     = 64;
  localparam int          DB     = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          S_LOAD = 0;
  localparam int          S_DONE = 1;
  localparam int          S_ERR  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        pc_hold = 1'b1;
  logic        chk_en  = 1'b0;
  logic        vld [2];
  logic [7:0]  dat [2];
  logic        lst [2];
  logic        rld [2];
  logic [31:0] pc  [2];
  int          tests = 0;
  int          fails = 0;

  logic [31:0] boot [0:8];
  logic [31:0] rnd  [0:63];

  imem_loader_if ifa ();
  imem_loader_if ifb ();
  assign ifa.ld_valid = vld[0];
  assign ifa.ld_data  = dat[0];
  assign ifa.ld_last  = lst[0];
  assign ifb.ld_valid = vld[1];
  assign ifb.ld_data  = dat[1];
  assign ifb.ld_last  = lst[1];

  logic [31:0] instr_a, instr_b;
  logic        cr_a, cr_b, dn_a, dn_b, er_a, er_b;
  logic [6:0]  wc_a;
  logic [2:0]  wc_b;

  imem_loader #(.DEPTH_WORDS(DA)) dut_a (
    .clk(clk), .reset(rst_n), .ld(ifa), .reload(rld[0]), .PC(pc[0]), .Instr(instr_a),
    .core_reset(cr_a), .load_done(dn_a), .load_err(er_a), .word_count(wc_a)
  );

  imem_loader #(.DEPTH_WORDS(DB)) dut_b (
    .clk(clk), .reset(rst_n), .ld(ifb), .reload(rld[1]), .PC(pc[1]), .Instr(instr_b),
    .core_reset(cr_b), .load_done(dn_b), .load_err(er_b), .word_count(wc_b)
  );

  // ---------------- reference model: the accepted byte list of the current load ----------------
  int         mstate [2];
  int         mcnt   [2];
  logic [7:0] mbuf   [2][0:255];
  int         depth  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mstate[k] = S_LOAD;
      mcnt[k]   = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (mstate[k] != S_LOAD) begin
        if (rld[k]) begin
          mstate[k] = S_LOAD;
          mcnt[k]   = 0;
        end
      end else if (vld[k]) begin
        if (mcnt[k] == 4 * depth[k]) begin
          mstate[k] = S_ERR;
        end else begin
          mbuf[k][mcnt[k]] = dat[k];
          mcnt[k]++;
          if (lst[k]) mstate[k] = (mcnt[k] % 4 == 0) ? S_DONE : S_ERR;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_instr(int k, logic [31:0] p);
    int idx;
    if (p >= $unsigned(4 * depth[k])) return NOP;
    idx = int'(p >> 2);
    if (idx >= mcnt[k] / 4) return NOP;
    return {mbuf[k][4*idx+3], mbuf[k][4*idx+2], mbuf[k][4*idx+1], mbuf[k][4*idx]};
  endfunction

  // ---------------- DUT observation helpers ----------------
  function automatic logic [31:0] ins(int k); return (k == 0) ? instr_a : instr_b; endfunction
  function automatic logic rdy(int k); return (k == 0) ? ifa.ld_ready : ifb.ld_ready; endfunction
  function automatic logic crs(int k); return (k == 0) ? cr_a : cr_b; endfunction
  function automatic logic dne(int k); return (k == 0) ? dn_a : dn_b; endfunction
  function automatic logic err(int k); return (k == 0) ? er_a : er_b; endfunction
  function automatic logic [31:0] wcn(int k); return (k == 0) ? 32'(wc_a) : 32'(wc_b); endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_k(int k);
    string t;
    t = (k == 0) ? "A" : "B";
    chk({t, ".ld_ready"},   32'(rdy(k)), 32'(mstate[k] == S_LOAD));
    chk({t, ".core_reset"}, 32'(crs(k)), 32'(mstate[k] != S_DONE));
    chk({t, ".load_done"},  32'(dne(k)), 32'(mstate[k] == S_DONE));
    chk({t, ".load_err"},   32'(err(k)), 32'(mstate[k] == S_ERR));
    chk({t, ".word_count"}, wcn(k), 32'(mcnt[k] / 4));
    chk({t, ".Instr"},      ins(k), exp_instr(k, pc[k]));
  endtask

  initial begin
    depth[0] = DA;
    depth[1] = DB;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        compare_k(0);
        compare_k(1);
      end
    end
  end

  // Random fetch addresses, biased toward the newest word to catch write-latency errors.
  initial begin
    forever begin
      @(negedge clk);
      if (!pc_hold) begin
        for (int k = 0; k < 2; k++) begin
          case ($urandom_range(0, 3))
            0:       pc[k] = $urandom();
            1:       pc[k] = (32'(mcnt[k] / 4) - $urandom_range(0, 1)) * 4 | 32'($urandom_range(0, 3));
            default: pc[k] = $urandom_range(0, 4 * depth[k] + 15);
          endcase
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_byte(int k, logic [7:0] d, logic l, int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      vld[k] = 1'b0;
    end
    @(negedge clk);
    vld[k] = 1'b1;
    dat[k] = d;
    lst[k] = l;
  endtask

  task automatic idle(int k);
    @(negedge clk);
    vld[k] = 1'b0;
    lst[k] = 1'b0;
    dat[k] = 8'($urandom());
  endtask

  task automatic send_prog(int k, int which, int n, bit last_end, int maxgap);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = (which == 0) ? boot[i] : rnd[i];
      for (int b = 0; b < 4; b++)
        send_byte(k, w[8*b +: 8], last_end && (i == n - 1) && (b == 3), $urandom_range(0, maxgap));
    end
  endtask

  task automatic pulse_reload(int k, bit with_byte);
    @(negedge clk);
    rld[k] = 1'b1;
    vld[k] = with_byte;
    dat[k] = 8'h5A;
    lst[k] = 1'b0;
    @(negedge clk);
    rld[k] = 1'b0;
    vld[k] = 1'b0;
  endtask

  task automatic chk_at(int k, logic [31:0] addr, logic [31:0] exp, string name);
    @(negedge clk);
    pc[k] = addr;
    #1;
    chk(name, ins(k), exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    boot = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
             32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463};
    for (int i = 0; i < 64; i++) rnd[i] = $urandom();
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; dat[k] = 8'h00; lst[k] = 1'b0; rld[k] = 1'b0; pc[k] = 32'h0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("reset.ld_ready",   32'(ifa.ld_ready), 32'd1);
    chk("reset.core_reset", 32'(cr_a), 32'd1);
    chk("reset.load_done",  32'(dn_a), 32'd0);
    chk("reset.load_err",   32'(er_a), 32'd0);
    chk("reset.word_count", 32'(wc_a), 32'd0);
    chk("reset.Instr",      instr_a, NOP);

    // 9-word boot
    send_prog(0, 0, 9, 1'b1, 0);
    idle(0);
    #1;
    chk("boot.core_reset", 32'(cr_a), 32'd0);
    chk("boot.load_done",  32'(dn_a), 32'd1);
    chk("boot.word_count", 32'(wc_a), 32'd9);
    chk_at(0, 32'h00, 32'h00500113, "boot.instr0");
    chk_at(0, 32'h18, 32'h02728863, "boot.instr18");
    chk_at(0, 32'h24, NOP,          "boot.instr24");
    chk_at(0, 32'h1B, 32'h02728863, "boot.lowbits");

    // Reload with a coincident byte, then a 2-word load
    pulse_reload(0, 1'b1);
    #1;
    chk("reload.core_reset", 32'(cr_a), 32'd1);
    chk("reload.word_count", 32'(wc_a), 32'd0);
    chk_at(0, 32'h00, NOP, "reload.instr0");
    chk_at(0, 32'h10, NOP, "reload.instr10");
    send_prog(0, 0, 2, 1'b1, 1);
    idle(0);
    #1;
    chk("reload2.word_count", 32'(wc_a), 32'd2);
    chk("reload2.load_done",  32'(dn_a), 32'd1);
    chk_at(0, 32'h00, 32'h00500113, "reload2.instr0");
    chk_at(0, 32'h08, NOP,          "reload2.instr8");

    // Boot again with random gaps on ld_valid
    pulse_reload(0, 1'b0);
    send_prog(0, 0, 9, 1'b1, 5);
    idle(0);
    #1;
    chk("gaps.word_count", 32'(wc_a), 32'd9);
    for (int i = 0; i < 10; i++)
      chk_at(0, 32'(4 * i), (i < 9) ? boot[i] : NOP, "gaps.sweep");

    // Partial last word: ld_last on the 6th byte
    pulse_reload(0, 1'b0);
    for (int b = 0; b < 6; b++) begin
      logic [31:0] w;
      w = boot[b / 4];
      send_byte(0, w[8*(b%4) +: 8], b == 5, 0);
    end
    idle(0);
    #1;
    chk("partial.load_err",   32'(er_a), 32'd1);
    chk("partial.core_reset", 32'(cr_a), 32'd1);
    chk("partial.word_count", 32'(wc_a), 32'd1);
    chk_at(0, 32'h04, NOP,          "partial.instr4");
    chk_at(0, 32'h00, 32'h00500113, "partial.instr0");

    // Reset in the middle of a load
    pulse_reload(0, 1'b0);
    send_byte(0, 8'hAA, 1'b0, 0);
    send_byte(0, 8'hBB, 1'b0, 0);
    idle(0);
    pc[0] = 32'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.word_count", 32'(wc_a), 32'd0);
    chk("midreset.ld_ready",   32'(ifa.ld_ready), 32'd1);
    chk_at(0, 32'h00, NOP, "midreset.instr0");
    chk_at(0, 32'h04, NOP, "midreset.instr4");
    @(negedge clk);
    rst_n = 1'b1;
    send_prog(0, 1, 5, 1'b1, 2);
    idle(0);
    #1;
    chk("fresh.load_done",  32'(dn_a), 32'd1);
    chk("fresh.word_count", 32'(wc_a), 32'd5);
    for (int i = 0; i < 6; i++)
      chk_at(0, 32'(4 * i), (i < 5) ? rnd[i] : NOP, "fresh.sweep");

    // Overflow on the 4-word instance
    send_prog(1, 1, 4, 1'b0, 0);
    send_byte(1, 8'hC3, 1'b0, 0);
    idle(1);
    #1;
    chk("ovf.load_err",   32'(er_b), 32'd1);
    chk("ovf.word_count", 32'(wc_b), 32'd4);
    chk("ovf.ld_ready",   32'(ifb.ld_ready), 32'd0);
    pulse_reload(1, 1'b0);
    send_prog(1, 1, 4, 1'b1, 1);
    idle(1);
    #1;
    chk("full.load_done",  32'(dn_b), 32'd1);
    chk("full.word_count", 32'(wc_b), 32'd4);
    chk_at(1, 32'h0C, rnd[3], "full.instrC");
    chk_at(1, 32'h10, NOP,    "full.instr10");

    // Randomized traffic on both instances
    pc_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 9) < 6);
        dat[k] = 8'($urandom());
        lst[k] = ($urandom_range(0, (k == 0) ? 120 : 20) == 0);
        rld[k] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; lst[k] = 1'b0; rld[k] = 1'b0;
    end
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction-memory block with a built-in byte-stream boot loader, sitting directly upstream of `processor_without_memory` and driving its `Instr` input from its `PC` output. After reset it holds the core in reset and accepts a little-endian byte stream over a valid/ready port. It packs the bytes into 32-bit words and writes them sequentially from address 0, then releases the core. Words that were never written read back as NOP, so a short program cannot execute stale contents.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: instruction words stored; power of two, ≥ 4.
- `ADDR_W`, $clog2(DEPTH_WORDS): word-address width, derived.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_last`  in  1  marks the final byte of the program; qualified by `ld_valid`.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `reload`  in  1  single-cycle request to restart loading.
- `PC`  in  32  fetch address from the core.
- `Instr`  out  32  instruction to the core; combinational.
- `core_reset`  out  1  active-high reset for the core; high while not in DONE.
- `load_done`  out  1  program loaded successfully.
- `load_err`  out  1  load aborted.
- `word_count`  out  ADDR_W+1  words written in the current load.

## Operation
- The state machine has three states: LOAD, DONE and ERR. The reset state is LOAD.
- A byte is accepted on a rising edge where `ld_valid && ld_ready`. `ld_ready` = (state == LOAD).
- `byte_idx` (2 bits) selects the lane in the assembly register, little-endian: byte 0 goes to [7:0] and byte 3 goes to [31:24].
- When the byte accepted at `byte_idx==3` completes a word:
  - the word is written to `mem[wr_ptr]` on that same edge;
  - `valid[wr_ptr]` is set;
  - `wr_ptr` and `word_count` increment and `byte_idx` wraps to 0.
- `ld_last` on an accepted byte:
  - with `byte_idx==3`: the word is written and the state moves to DONE;
  - with `byte_idx!=3`: the partial word is discarded and the state moves to ERR.
- Overflow: a byte accepted while `wr_ptr == DEPTH_WORDS` moves the state to ERR. Nothing is written.
- In DONE and ERR, incoming bytes are ignored and `ld_ready` is 0.
- `reload` in DONE or ERR:
  - clears `valid[]`, `wr_ptr`, `byte_idx` and `word_count`;
  - returns the state to LOAD, which raises `core_reset`.
- `reload` in LOAD is ignored.
- `Instr` is `valid[PC[ADDR_W+1:2]] ? mem[PC[ADDR_W+1:2]] : 32'h00000013`.
  - If `PC[31:ADDR_W+2]` is nonzero, `Instr` is NOP.
  - `PC[1:0]` is ignored.
- Output decodes:
  - `core_reset` = (state != DONE);
  - `load_done` = (state == DONE);
  - `load_err` = (state == ERR).

## Timing
- Reset values:
  - state LOAD, `ld_ready` 1, `core_reset` 1, `load_done` 0, `load_err` 0, `word_count` 0;
  - `valid[]` all 0, so `Instr` reads NOP;
  - `mem[]` contents are not reset.
- Write latency: a word is readable through `Instr` in the cycle after the edge that accepted its fourth byte.
- On the edge that accepts the last byte, the state becomes DONE. `core_reset` falls immediately after that edge, and the core's first fetch sees the complete program.
- `ld_valid` may be deasserted between bytes for any number of cycles. The assembly register and `byte_idx` hold.
- Asserting `reset` mid-load returns asynchronously to the reset values. A partial word is lost.
- `reload` and `ld_valid` asserted together in DONE or ERR: `reload` wins and no byte is accepted that cycle.
- Overflow edge case: in a load of exactly `DEPTH_WORDS` words whose last byte has `ld_last` set, the state reaches DONE, not ERR.

## Structure
- Package `imem_loader_pkg` holds:
  - typedef enum logic [1:0] `loader_state_t` {LOAD, DONE, ERR};
  - constant `NOP_INSTR` = 32'h00000013.
- Sub-module `imem_array`: `DEPTH_WORDS` × 32 storage plus the valid-bit vector.
  - Write port: `we`, `waddr`, `wdata`; plus `clr_valid`.
  - Asynchronous read port returning the word or `NOP_INSTR`.
- The top level holds the FSM, the byte assembler, `wr_ptr` and the PC range check.

## Test plan
- **Boot a 9-word program.** Stream the 36 bytes of 00500113, 00C00193, FF718393, 0023E233, 0041F2B3, 004282B3, 02728863, 0041A233, 00020463 (first bytes 13 01 50 00), with `ld_last` on the final byte.
  - During the load: `core_reset` stays 1.
  - After the last byte: `core_reset` 0, `load_done` 1, `word_count` 9.
  - `Instr` = 00500113 at PC=0, 02728863 at PC=0x18, and NOP at PC=0x24.
- **Backpressure gaps.** Repeat the boot with random 0–5-cycle gaps on `ld_valid` -> identical memory contents and `word_count`.
- **Partial last word.** `ld_last` on the 6th byte -> `load_err` 1, `core_reset` stays 1, `word_count` 1, `Instr` at PC=4 is NOP.
- **Overflow.** With `DEPTH_WORDS`=4, stream 5 words without `ld_last` -> ERR on the first byte of word 5, `word_count` 4. Then 4 words with `ld_last` on word 4 -> DONE.
- **Reset mid-load.** Pull `reset` low after 2 bytes -> `word_count` 0, `Instr` NOP everywhere, `ld_ready` 1. A fresh load then succeeds.
- **Reload.** From DONE, pulse `reload` together with `ld_valid` -> `core_reset` 1, all addresses read NOP, and the coincident byte is not accepted. A 2-word reload then yields `word_count` 2.
